// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 pixel feeder and its driver.
// Holds the pixel width, the driver bit-timing constants and the feeder FSM encoding.
package ws2812_pkg;

    localparam int PIX_W = 24;

    // Serial driver timing, nanoseconds per WS2812 datasheet
    localparam int T0H_NS  = 400;
    localparam int T1H_NS  = 800;
    localparam int TBIT_NS = 1250;
    localparam int TRST_NS = 280_000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } feed_state_t;

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Pixel RAM: single write port, synchronous read port (1-cycle latency).
// Ports: clk, rst_n, wr_en/wr_addr/wr_data (host), rd_en/rd_addr -> rd_data.
module ws2812_pixel_ram #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [2**IDX_W];
    logic             wr_ok;

    // Out-of-range host writes are dropped
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_C);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    // Read register doubles as the pixel output register; it only
    // updates on rd_en so it holds still while the driver stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ws2812_pixel_feeder.sv
// Streams one frame of GRB pixels from the pixel RAM to the WS2812 driver per refresh tick or host request.
// Ports: host write (wr_*), frame_req, pixel stream (pix_valid/data/last, pix_ready), frame_busy, frame_done.
module ws2812_pixel_feeder
    import ws2812_pkg::*;
#(
    parameter int LED_NUM    = 8,
    parameter int DATA_WIDTH = PIX_W,
    parameter int ADDR_W     = 8,
    parameter int CLK_FRE    = 50_000_000,
    parameter int REFRESH_HZ = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  frame_req,
    output logic                  pix_valid,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_last,
    input  logic                  pix_ready,
    output logic                  frame_busy,
    output logic                  frame_done
);

    localparam int REFRESH_DIV = CLK_FRE / REFRESH_HZ;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LED_NUM - 1);

    feed_state_t      state;
    logic [CNT_W-1:0] refresh_cnt;
    logic [IDX_W-1:0] idx;
    logic             pending;
    logic             tick;
    logic             trig;
    logic             start;

    assign tick  = (refresh_cnt == CNT_LAST);
    assign trig  = tick || frame_req;
    // A trigger arriving while idle starts the frame directly
    assign start = (state == IDLE) && (pending || trig);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending    <= 1'b0;
            idx        <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // Any number of triggers during a frame collapse into one
            if (start) begin
                pending <= 1'b0;
            end else if (trig) begin
                pending <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= '0;
                        frame_busy <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    pix_valid <= 1'b1;
                    pix_last  <= (idx == IDX_LAST);
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (pix_last) begin
                            pix_last   <= 1'b0;
                            frame_busy <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    ws2812_pixel_ram #(
        .DEPTH  (LED_NUM),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state == LOAD),
        .rd_addr (idx),
        .rd_data (pix_data)
    );

endmodule

// File: tb/tb_ws2812_pixel_feeder.sv
// Scoreboard bench for ws2812_pixel_feeder (LED_NUM=4, refresh period 2000 cycles).
// Stimulus pushes expected pixels; a negedge monitor pops them on every transfer.
module tb_ws2812_pixel_feeder;

    localparam int LED_NUM = 4;
    localparam int DW      = 24;
    localparam int AW      = 8;
    localparam int DIV     = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_req;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_last;
    logic          pix_ready;
    logic          frame_busy;
    logic          frame_done;

    always #5 clk = ~clk;

    ws2812_pixel_feeder #(
        .LED_NUM    (LED_NUM),
        .DATA_WIDTH (DW),
        .ADDR_W     (AW),
        .CLK_FRE    (DIV),
        .REFRESH_HZ (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_req  (frame_req),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [LED_NUM];
    int            checks   = 0;
    int            passed   = 0;
    int            xfer_cnt = 0;
    int            done_cnt = 0;
    int            since    = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        wr_en   = 1'b0;
        if (a < LED_NUM) model[a] = d;
    endtask

    task automatic push_pix(input int i);
        exp_t e;
        e.d = model[i];
        e.l = (i == LED_NUM - 1);
        exp_q.push_back(e);
    endtask

    task automatic push_frame();
        for (int i = 0; i < LED_NUM; i++) push_pix(i);
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 1000) begin
            step();
            n++;
        end
        check(done_cnt == target, name, done_cnt, target);
    endtask

    task automatic wait_xfer(input int target, input string name);
        int n = 0;
        while (xfer_cnt < target && n < 1000) begin
            step();
            n++;
        end
        check(xfer_cnt == target, name, xfer_cnt, target);
    endtask

    // Count of non-reset clock edges, mirrors the refresh phase
    initial forever begin
        @(posedge clk);
        since = rst_n ? since + 1 : 0;
    end

    // Monitor: transfer scoreboard, stall stability, frame_done placement
    initial begin
        bit            stall_prev = 0;
        bit            last_prev  = 0;
        logic [DW-1:0] hd = '0;
        logic          hl = 1'b0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
                last_prev  = 0;
            end else begin
                if (stall_prev)
                    check(pix_valid && pix_data == hd && pix_last == hl,
                          "stall_hold", pix_data, hd);
                if (frame_done) begin
                    done_cnt++;
                    check(last_prev, "done_after_last", 32'(last_prev), 1);
                end
                last_prev = 0;
                if (pix_valid && pix_ready) begin
                    xfer_cnt++;
                    check(exp_q.size() > 0, "xfer_expected", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check(pix_data == e.d, "pix_data", pix_data, e.d);
                        check(pix_last == e.l, "pix_last", 32'(pix_last), 32'(e.l));
                    end
                    last_prev = pix_last;
                end
                stall_prev = pix_valid && !pix_ready;
                hd = pix_data;
                hl = pix_last;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        bit seen;
        int base;
        int n;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        frame_req = 1'b0; pix_ready = 1'b1;
        step();
        step();
        check({pix_valid, pix_last, frame_busy, frame_done} == 4'b0 && pix_data == '0,
              "reset_outputs", {pix_valid, pix_last, frame_busy, frame_done}, 0);

        // Refresh tick frame: writes land before the first tick
        model[0] = 24'h111111; model[1] = 24'h222222;
        model[2] = 24'h333333; model[3] = 24'h444444;
        push_frame();
        rst_n = 1'b1;
        cyc   = 0;
        seen  = 0;
        while (!seen && cyc < DIV + 50) begin
            if (cyc < LED_NUM) begin
                wr_en = 1'b1; wr_addr = AW'(cyc); wr_data = model[cyc];
            end else begin
                wr_en = 1'b0;
            end
            step();
            cyc++;
            if (pix_valid) seen = 1;
        end
        wr_en = 1'b0;
        check(cyc == DIV + 1, "first_tick_latency", cyc, DIV + 1);
        wait_done(1, "tick_frame_done");
        check(exp_q.size() == 0, "tick_frame_drained", exp_q.size(), 0);

        // Host request frame
        wr(0, 24'h00FF00);
        wr(1, 24'hFF0000);
        wr(2, 24'h0000FF);
        wr(3, 24'h123456);
        push_frame();
        pulse_req();
        check(frame_busy && !pix_valid, "load_busy", {frame_busy, pix_valid}, 2);
        step();
        check(pix_valid && pix_data == 24'h00FF00, "req_latency", pix_data, 24'h00FF00);
        wait_done(2, "req_frame_done");
        check(!frame_busy && exp_q.size() == 0, "req_frame_idle", frame_busy, 0);

        // Backpressure on pixel 1
        push_frame();
        base = xfer_cnt;
        pulse_req();
        wait_xfer(base + 1, "bp_first_xfer");
        pix_ready = 1'b0;
        repeat (100) step();
        check(pix_valid && pix_data == model[1] && !pix_last, "bp_held", pix_data, model[1]);
        pix_ready = 1'b1;
        wait_done(3, "bp_frame_done");

        // Requests and a tick during a stalled frame yield one extra frame
        n = 0;
        while (since < 2 * DIV - 20 && n < 3 * DIV) begin
            step();
            n++;
        end
        pix_ready = 1'b0;
        push_frame();
        push_frame();
        pulse_req();
        repeat (5) step();
        pulse_req();
        repeat (5) step();
        pulse_req();
        repeat (30) step();
        check(since > 2 * DIV, "tick_passed", since, 2 * DIV);
        check(pix_valid && frame_busy, "collapse_stalled", {pix_valid, frame_busy}, 3);
        pix_ready = 1'b1;
        wait_done(5, "collapse_frames");
        repeat (20) step();
        check(done_cnt == 5 && exp_q.size() == 0, "no_extra_frame", done_cnt, 5);
        check(!frame_busy && !pix_valid, "collapse_idle", {frame_busy, pix_valid}, 0);

        // Reset while pixel 2 is presented
        push_pix(0);
        push_pix(1);
        base = xfer_cnt;
        pulse_req();
        wait_xfer(base + 2, "rst_two_xfers");
        pix_ready = 1'b0;
        n = 0;
        while (!pix_valid && n < 20) begin
            step();
            n++;
        end
        check(pix_valid && pix_data == model[2], "pix2_present", pix_data, model[2]);
        rst_n = 1'b0;
        step();
        check({pix_valid, pix_last, frame_busy, frame_done} == 4'b0 && pix_data == '0,
              "midframe_reset", {pix_valid, pix_last, frame_busy, frame_done}, 0);
        rst_n = 1'b1;
        pix_ready = 1'b1;
        repeat (10) step();
        check(done_cnt == 5 && exp_q.size() == 0, "no_done_on_reset", done_cnt, 5);
        push_frame();
        pulse_req();
        wait_done(6, "post_reset_frame");

        // Out-of-range write leaves RAM untouched
        wr(LED_NUM, 24'hFFFFFF);
        wr(255, 24'hFFFFFF);
        push_frame();
        pulse_req();
        wait_done(7, "oob_frame_done");
        check(exp_q.size() == 0, "oob_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
